coin_button_debouncer: RTL and testbench

- Consumer of the periodic one-cycle enable strobe produced by the clock-enable generator. Conditions raw vending-machine pushbuttons (coin inputs, select, cancel): synchronizes them, debounces them on enable ticks, and emits clean levels and one-cycle press pulses.
- Press events are also queued as single-entry-per-channel pending flags and delivered to the vending FSM over a valid/ready handshake, so no coin press is lost while the FSM is busy.

---
 rtl/coin_button_debouncer_pkg.sv | 16 +
 rtl/coin_button_debouncer_channel.sv | 62 ++++++
 rtl/coin_button_debouncer.sv | 83 ++++++++
 tb/tb_coin_button_debouncer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_button_debouncer_pkg.sv
// Shared definitions for the coin/button front end and the vending FSM that
// consumes its events: channel count, event id width and channel indices.
package coin_button_debouncer_pkg;

    localparam int NBTN          = 5;
    localparam int IDW           = 3;
    localparam int DEFAULT_DEPTH = 4;

    // Channel indices as presented on evt_id.
    localparam logic [IDW-1:0] CH_NICKEL  = 3'd0;
    localparam logic [IDW-1:0] CH_DIME    = 3'd1;
    localparam logic [IDW-1:0] CH_QUARTER = 3'd2;
    localparam logic [IDW-1:0] CH_SELECT  = 3'd3;
    localparam logic [IDW-1:0] CH_CANCEL  = 3'd4;

endpackage

// File: rtl/coin_button_debouncer_channel.sv
// One button channel: two-flop synchronizer, tick-sampled history, debounced
// level and a one-cycle pulse on each debounced rising edge.
module debounce_channel
    import coin_button_debouncer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic clk,
    input  logic clr,
    input  logic tick,
    input  logic raw,
    output logic lvl,
    output logic press
);

    logic             sync1;
    logic             sync2;
    logic [DEPTH-1:0] hist;
    logic [DEPTH-1:0] hist_next;
    logic             qualify;

    // Bring the asynchronous button into the clk domain, every cycle.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Level flips when the history including the sample being shifted in
    // is entirely the opposite of the current level; any odd sample resets it.
    always_comb begin
        hist_next = {hist[DEPTH-2:0], sync2};
        qualify   = tick && (hist_next == {DEPTH{~lvl}});
    end

    // Shift the synchronized value into the history only on tick.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hist <= '0;
        end else if (tick) begin
            hist <= hist_next;
        end
    end

    // Debounced level and its rising-edge pulse, both registered together.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            lvl   <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= qualify && !lvl;
            if (qualify) begin
                lvl <= ~lvl;
            end
        end
    end

endmodule

// File: rtl/coin_button_debouncer.sv
// Button front end for the vending machine: per-channel debouncers plus a
// pending flag per channel so presses are held until the FSM takes them.
//
// Event handshake: evt_valid is high while any press is pending and evt_id
// names the lowest pending channel; a transfer happens on every clk edge
// where evt_valid && evt_ready, clearing that channel's flag. evt_ready with
// evt_valid low has no effect. A press arriving in the same cycle its own
// channel is accepted keeps the flag set (the new press is not lost).
module coin_button_debouncer #(
    parameter int NBTN  = coin_button_debouncer_pkg::NBTN,
    parameter int DEPTH = coin_button_debouncer_pkg::DEFAULT_DEPTH,
    parameter int IDW   = coin_button_debouncer_pkg::IDW
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            tick,
    input  logic [NBTN-1:0] btn_raw,
    output logic [NBTN-1:0] btn_lvl,
    output logic [NBTN-1:0] btn_press,
    output logic            evt_valid,
    output logic [IDW-1:0]  evt_id,
    input  logic            evt_ready,
    output logic            overrun
);

    logic [NBTN-1:0] pend;
    logic [NBTN-1:0] accept_mask;
    logic [IDW-1:0]  evt_id_c;
    logic            accept;

    for (genvar g = 0; g < NBTN; g++) begin : g_chan
        debounce_channel #(
            .DEPTH (DEPTH)
        ) u_chan (
            .clk   (clk),
            .clr   (clr),
            .tick  (tick),
            .raw   (btn_raw[g]),
            .lvl   (btn_lvl[g]),
            .press (btn_press[g])
        );
    end

    // Fixed priority: lowest pending channel index wins; 0 when nothing pends.
    always_comb begin
        evt_id_c = '0;
        for (int i = NBTN - 1; i >= 0; i--) begin
            if (pend[i]) begin
                evt_id_c = IDW'(i);
            end
        end
    end

    // One-hot of the channel being handed over this cycle.
    always_comb begin
        accept = evt_valid && evt_ready;
        for (int i = 0; i < NBTN; i++) begin
            accept_mask[i] = accept && (evt_id_c == IDW'(i));
        end
    end

    assign evt_valid = |pend;
    assign evt_id    = evt_id_c;

    // Pending flags: accept clears, a new press sets, and set takes priority.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~accept_mask) | btn_press;
        end
    end

    // Flag a press that lands on a channel still waiting and not leaving now.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            overrun <= 1'b0;
        end else begin
            overrun <= |(btn_press & pend & ~accept_mask);
        end
    end

endmodule

// File: tb/tb_coin_button_debouncer.sv
// Directed bench for coin_button_debouncer with DEPTH=4.
module tb_coin_button_debouncer;
    import coin_button_debouncer_pkg::*;

    localparam int DEPTH_T = 4;

    logic            clk = 1'b0;
    logic            clr = 1'b0;
    logic            tick = 1'b0;
    logic            evt_ready = 1'b0;
    logic [NBTN-1:0] btn_raw = '0;
    logic [NBTN-1:0] btn_lvl;
    logic [NBTN-1:0] btn_press;
    logic            evt_valid;
    logic [IDW-1:0]  evt_id;
    logic            overrun;

    int checks = 0;
    int failures = 0;
    int press_cnt [NBTN];
    int overrun_cnt = 0;
    logic [IDW-1:0] exp_q [$];

    coin_button_debouncer #(
        .NBTN  (NBTN),
        .DEPTH (DEPTH_T),
        .IDW   (IDW)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .tick      (tick),
        .btn_raw   (btn_raw),
        .btn_lvl   (btn_lvl),
        .btn_press (btn_press),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_ready (evt_ready),
        .overrun   (overrun)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Pulse counters sampled on the inactive edge.
    always @(negedge clk) begin
        for (int i = 0; i < NBTN; i++) begin
            if (btn_press[i] === 1'b1) press_cnt[i]++;
        end
        if (overrun === 1'b1) overrun_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // One-cycle tick; returns just after the sampling edge.
    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NBTN; i++) press_cnt[i] = 0;
        overrun_cnt = 0;
    endtask

    // Drive a stable pattern and stop right after the qualifying tick edge.
    task automatic press_until(input logic [NBTN-1:0] mask);
        btn_raw = mask;
        idle(2);
        repeat (DEPTH_T - 1) begin
            do_tick();
            idle(1);
        end
        do_tick();
    endtask

    task automatic release_all();
        btn_raw = '0;
        idle(2);
        repeat (DEPTH_T) begin
            do_tick();
            idle(1);
        end
    endtask

    task automatic accept_one();
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [IDW-1:0] exp;
        clear_counts();
        clr = 1'b0;
        btn_raw = '1;
        for (int k = 0; k < 12; k++) begin
            tick = (k % 2 == 0);
            step();
            checks++;
            if ({btn_lvl, btn_press, evt_valid, overrun} !== '0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d: lvl=%b press=%b valid=%b ovr=%b, want all 0",
                         k, btn_lvl, btn_press, evt_valid, overrun);
            end
        end
        tick = 1'b0;
        clr = 1'b1;
        idle(2);
        repeat (DEPTH_T - 1) begin
            do_tick();
            idle(1);
        end
        checks++;
        if (btn_lvl !== 5'b00000) begin
            failures++;
            $display("FAIL reset_early_lvl: lvl=%b want 00000", btn_lvl);
        end
        do_tick();
        checks++;
        if (btn_lvl !== 5'b11111 || btn_press !== 5'b11111) begin
            failures++;
            $display("FAIL reset_release_lvl: lvl=%b press=%b want 11111/11111", btn_lvl, btn_press);
        end
        step();
        for (int k = 0; k < NBTN; k++) exp_q.push_back(IDW'(k));
        evt_ready = 1'b1;
        for (int k = 0; k < NBTN; k++) begin
            exp = exp_q.pop_front();
            checks++;
            if (evt_valid !== 1'b1 || evt_id !== exp) begin
                failures++;
                $display("FAIL reset_drain k=%0d: valid=%b id=%0d want 1/%0d", k, evt_valid, evt_id, exp);
            end
            step();
        end
        evt_ready = 1'b0;
        checks++;
        if (evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_drain_empty: valid=%b want 0", evt_valid);
        end
        release_all();
        checks++;
        if (btn_lvl !== 5'b00000 || press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] + press_cnt[4] != 5) begin
            failures++;
            $display("FAIL reset_release_all: lvl=%b presses=%0d want 00000/5", btn_lvl,
                     press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] + press_cnt[4]);
        end
    endtask

    task automatic test_bounce();
        clear_counts();
        for (int t = 0; t < 20; t++) begin
            btn_raw[1] = ((t / 3) % 2) == 1;
            idle(2);
            do_tick();
        end
        checks++;
        if (press_cnt[1] != 0 || btn_lvl !== 5'b00000) begin
            failures++;
            $display("FAIL bounce_reject: presses=%0d lvl=%b want 0/00000", press_cnt[1], btn_lvl);
        end
        btn_raw[1] = 1'b1;
        idle(2);
        repeat (DEPTH_T - 1) begin
            do_tick();
            idle(1);
        end
        checks++;
        if (btn_lvl !== 5'b00000) begin
            failures++;
            $display("FAIL bounce_early: lvl=%b want 00000", btn_lvl);
        end
        do_tick();
        checks++;
        if (btn_press !== 5'b00010 || btn_lvl !== 5'b00010) begin
            failures++;
            $display("FAIL bounce_press: press=%b lvl=%b want 00010/00010", btn_press, btn_lvl);
        end
        step();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== CH_DIME || btn_press !== 5'b00000) begin
            failures++;
            $display("FAIL bounce_event: valid=%b id=%0d press=%b want 1/1/00000", evt_valid, evt_id, btn_press);
        end
        accept_one();
        checks++;
        if (evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL bounce_accept: valid=%b want 0", evt_valid);
        end
        release_all();
        checks++;
        if (press_cnt[1] != 1 || btn_lvl !== 5'b00000) begin
            failures++;
            $display("FAIL bounce_single_pulse: presses=%0d lvl=%b want 1/00000", press_cnt[1], btn_lvl);
        end
    endtask

    task automatic test_priority();
        clear_counts();
        press_until(5'b00101);
        checks++;
        if (btn_press !== 5'b00101) begin
            failures++;
            $display("FAIL prio_press: press=%b want 00101", btn_press);
        end
        step();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== CH_NICKEL) begin
            failures++;
            $display("FAIL prio_first: valid=%b id=%0d want 1/0", evt_valid, evt_id);
        end
        accept_one();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== CH_QUARTER) begin
            failures++;
            $display("FAIL prio_second: valid=%b id=%0d want 1/2", evt_valid, evt_id);
        end
        accept_one();
        checks++;
        if (evt_valid !== 1'b0 || evt_id !== 3'd0) begin
            failures++;
            $display("FAIL prio_empty: valid=%b id=%0d want 0/0", evt_valid, evt_id);
        end
        accept_one();
        checks++;
        if (evt_valid !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL prio_idle_ready: valid=%b ovr=%b want 0/0", evt_valid, overrun);
        end
        release_all();
    endtask

    task automatic test_overrun();
        clear_counts();
        press_until(5'b01000);
        step();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== CH_SELECT) begin
            failures++;
            $display("FAIL ovr_first: valid=%b id=%0d want 1/3", evt_valid, evt_id);
        end
        release_all();
        press_until(5'b01000);
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL ovr_before: ovr=%b want 0", overrun);
        end
        step();
        checks++;
        if (overrun !== 1'b1 || evt_valid !== 1'b1 || evt_id !== CH_SELECT) begin
            failures++;
            $display("FAIL ovr_pulse: ovr=%b valid=%b id=%0d want 1/1/3", overrun, evt_valid, evt_id);
        end
        step();
        checks++;
        if (overrun !== 1'b0 || overrun_cnt != 1) begin
            failures++;
            $display("FAIL ovr_width: ovr=%b count=%0d want 0/1", overrun, overrun_cnt);
        end
        release_all();
        press_until(5'b01000);
        accept_one();
        checks++;
        if (overrun !== 1'b0 || evt_valid !== 1'b1 || evt_id !== CH_SELECT) begin
            failures++;
            $display("FAIL ovr_set_wins: ovr=%b valid=%b id=%0d want 0/1/3", overrun, evt_valid, evt_id);
        end
        idle(2);
        checks++;
        if (overrun_cnt != 1) begin
            failures++;
            $display("FAIL ovr_set_wins_count: count=%0d want 1", overrun_cnt);
        end
        accept_one();
        checks++;
        if (evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovr_final_accept: valid=%b want 0", evt_valid);
        end
        release_all();
    endtask

    task automatic test_tick_gating();
        int changed;
        clear_counts();
        changed = 0;
        tick = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            btn_raw[4] = 1'($urandom_range(0, 1));
            step();
            if (btn_lvl !== 5'b00000) changed++;
        end
        checks++;
        if (changed != 0 || press_cnt[4] != 0) begin
            failures++;
            $display("FAIL gate_hold: lvl_nonzero_cycles=%0d presses=%0d want 0/0", changed, press_cnt[4]);
        end
        btn_raw[4] = 1'b1;
        idle(2);
        repeat (DEPTH_T - 1) begin
            do_tick();
            idle(1);
        end
        checks++;
        if (btn_lvl !== 5'b00000) begin
            failures++;
            $display("FAIL gate_early: lvl=%b want 00000", btn_lvl);
        end
        do_tick();
        checks++;
        if (btn_lvl !== 5'b10000 || btn_press !== 5'b10000) begin
            failures++;
            $display("FAIL gate_qualify: lvl=%b press=%b want 10000/10000", btn_lvl, btn_press);
        end
        step();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== CH_CANCEL) begin
            failures++;
            $display("FAIL gate_event: valid=%b id=%0d want 1/4", evt_valid, evt_id);
        end
        accept_one();
        release_all();
    endtask

    task automatic test_reset_mid();
        clear_counts();
        press_until(5'b00001);
        step();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== CH_NICKEL) begin
            failures++;
            $display("FAIL mid_pending: valid=%b id=%0d want 1/0", evt_valid, evt_id);
        end
        btn_raw = 5'b00010;
        idle(2);
        do_tick();
        idle(1);
        do_tick();
        idle(1);
        clr = 1'b0;
        #1;
        checks++;
        if ({btn_lvl, btn_press, evt_valid, evt_id, overrun} !== '0) begin
            failures++;
            $display("FAIL mid_async_clear: lvl=%b press=%b valid=%b id=%0d ovr=%b want all 0",
                     btn_lvl, btn_press, evt_valid, evt_id, overrun);
        end
        step();
        clr = 1'b1;
        idle(2);
        repeat (DEPTH_T - 1) begin
            do_tick();
            idle(1);
        end
        checks++;
        if (btn_lvl !== 5'b00000 || evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_fresh_history: lvl=%b valid=%b want 00000/0", btn_lvl, evt_valid);
        end
        do_tick();
        checks++;
        if (btn_lvl !== 5'b00010 || btn_press !== 5'b00010) begin
            failures++;
            $display("FAIL mid_requalify: lvl=%b press=%b want 00010/00010", btn_lvl, btn_press);
        end
        step();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== CH_DIME) begin
            failures++;
            $display("FAIL mid_event: valid=%b id=%0d want 1/1", evt_valid, evt_id);
        end
        accept_one();
        release_all();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        clear_counts();
        test_reset();
        test_bounce();
        test_priority();
        test_overrun();
        test_tick_gating();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1);
    end

endmodule
